sm_uart_loader: RTL

Serial program loader for the schoolMIPS core. It receives a framed program image over a UART line and assembles it into 32-bit words. It writes those words sequentially into the instruction memory that the CPU fetches from, so it is the writer at the other end of the CPU's instruction-fetch read port. While a load is in progress it holds the CPU in reset, and it releases the CPU only after the image checksum passes.

---
 rtl/sm_uart_loader.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sm_uart_loader.sv
// sm_uart_loader: UART program loader for the schoolMIPS instruction memory.
// Receives a framed image (55 AA N_hi N_lo {N x 4 data bytes} csum) at 8N1.
// It writes each assembled big-endian word to sequential word addresses.
// The CPU is held in reset from header acceptance until a good checksum.
// Optional feature macro: SM_UART_LOADER_TIMEOUT_EN. When it is defined, an
// inter-byte timeout of 160*BAUD_DIV cycles aborts a stalled frame.
module sm_uart_loader #(
    parameter int BAUD_DIV   = 434,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  imWe,
    output logic [ADDR_WIDTH-1:0] imWAddr,
    output logic [31:0]           imWData,
    output logic                  cpuRst,
    output logic                  busy,
    output logic                  loadErr
);

    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    rxState_t    rxState, rxStateNext;
    logic [1:0]  rxSync;
    logic        rxPrev;
    logic        rxS;
    logic        rxFall;
    logic [15:0] baudCnt, baudCntNext;
    logic [2:0]  bitIdx, bitIdxNext;
    logic [7:0]  rxShift, rxShiftNext;
    logic        byteValid;
    logic        frameErr;

    assign rxS    = rxSync[1];
    assign rxFall = rxPrev & ~rxS;

    // Two-flop synchronizer plus the previous sample used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rxSync <= 2'b11;
            rxPrev <= 1'b1;
        end else begin
            rxSync <= {rxSync[0], rx};
            rxPrev <= rxS;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rxState <= RX_IDLE;
            baudCnt <= '0;
            bitIdx  <= '0;
            rxShift <= '0;
        end else begin
            rxState <= rxStateNext;
            baudCnt <= baudCntNext;
            bitIdx  <= bitIdxNext;
            rxShift <= rxShiftNext;
        end
    end

    // Receiver next state. Bits are sampled mid-bit; the start bit is re-checked at half a bit.
    always_comb begin
        rxStateNext = rxState;
        baudCntNext = baudCnt;
        bitIdxNext  = bitIdx;
        rxShiftNext = rxShift;
        byteValid   = 1'b0;
        frameErr    = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (rxFall) begin
                    rxStateNext = RX_START;
                    baudCntNext = '0;
                end
            end
            RX_START: begin
                if (baudCnt == HALF_LAST) begin
                    baudCntNext = '0;
                    bitIdxNext  = '0;
                    // A line that is high again at mid-start was only a glitch
                    rxStateNext = rxS ? RX_IDLE : RX_DATA;
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (baudCnt == FULL_LAST) begin
                    baudCntNext = '0;
                    rxShiftNext = {rxS, rxShift[7:1]};
                    bitIdxNext  = bitIdx + 3'd1;
                    if (bitIdx == 3'd7)
                        rxStateNext = RX_STOP;
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (baudCnt == FULL_LAST) begin
                    baudCntNext = '0;
                    byteValid   = rxS;
                    frameErr    = ~rxS;
                    // Back to idle at mid-stop so a back-to-back start edge is caught
                    rxStateNext = RX_IDLE;
                end else begin
                    baudCntNext = baudCnt + 16'd1;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_CSUM
    } frState_t;

    frState_t              state, stateNext;
    logic [7:0]            cntHi, cntHiNext;
    logic [15:0]           wordsLeft, wordsLeftNext;
    logic [1:0]            byteIdx, byteIdxNext;
    logic [23:0]           wordAsm, wordAsmNext;
    logic [7:0]            csum, csumNext;
    logic [ADDR_WIDTH-1:0] wordAddr, wordAddrNext;
    logic                  imWeNext;
    logic [31:0]           imWDataNext;
    logic                  cpuRstNext;
    logic                  loadErrNext;
    logic [15:0]           rxCount;

    assign rxCount = {cntHi, rxShift};
    assign imWAddr = wordAddr;
    assign busy    = (state != ST_IDLE);

`ifdef SM_UART_LOADER_TIMEOUT_EN
    localparam int          TO_LIMIT = 160 * BAUD_DIV;
    localparam logic [23:0] TO_LAST  = 24'(TO_LIMIT - 1);

    logic [23:0] timer;
    logic        timeoutHit;

    // Inter-byte timer: counts cycles since the last byte, parked in idle
    always_ff @(posedge clk) begin
        if (rst)
            timer <= 24'd1;
        else if (byteValid || state == ST_IDLE)
            timer <= 24'd1;
        else if (timer != TO_LAST)
            timer <= timer + 24'd1;
    end

    assign timeoutHit = (state != ST_IDLE) && (timer == TO_LAST);
`endif

    // Frame state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cntHi     <= '0;
            wordsLeft <= '0;
            byteIdx   <= '0;
            wordAsm   <= '0;
            csum      <= '0;
            wordAddr  <= '0;
            imWe      <= 1'b0;
            imWData   <= '0;
            cpuRst    <= 1'b0;
            loadErr   <= 1'b0;
        end else begin
            state     <= stateNext;
            cntHi     <= cntHiNext;
            wordsLeft <= wordsLeftNext;
            byteIdx   <= byteIdxNext;
            wordAsm   <= wordAsmNext;
            csum      <= csumNext;
            wordAddr  <= wordAddrNext;
            imWe      <= imWeNext;
            imWData   <= imWDataNext;
            cpuRst    <= cpuRstNext;
            loadErr   <= loadErrNext;
        end
    end

    // Frame next state: header match, count capture, word assembly, checksum
    always_comb begin
        stateNext     = state;
        cntHiNext     = cntHi;
        wordsLeftNext = wordsLeft;
        byteIdxNext   = byteIdx;
        wordAsmNext   = wordAsm;
        csumNext      = csum;
        // Address moves on in the cycle after the write strobe
        wordAddrNext  = imWe ? wordAddr + ADDR_WIDTH'(1) : wordAddr;
        imWeNext      = 1'b0;
        imWDataNext   = imWData;
        cpuRstNext    = cpuRst;
        loadErrNext   = loadErr;

        if (frameErr) begin
            // Idle framing errors drop the byte only; mid-frame they abort
            if (state != ST_IDLE) begin
                loadErrNext = 1'b1;
                stateNext   = ST_IDLE;
            end
        end else if (byteValid) begin
            case (state)
                ST_IDLE: begin
                    if (rxShift == 8'h55)
                        stateNext = ST_HDR;
                end
                ST_HDR: begin
                    if (rxShift == 8'hAA) begin
                        stateNext    = ST_CNT_HI;
                        cpuRstNext   = 1'b1;
                        loadErrNext  = 1'b0;
                        wordAddrNext = '0;
                        csumNext     = '0;
                    end else if (rxShift != 8'h55) begin
                        stateNext = ST_IDLE;
                    end
                end
                ST_CNT_HI: begin
                    cntHiNext = rxShift;
                    stateNext = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    wordsLeftNext = rxCount;
                    byteIdxNext   = '0;
                    stateNext     = (rxCount == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    csumNext    = csum ^ rxShift;
                    wordAsmNext = {wordAsm[15:0], rxShift};
                    byteIdxNext = byteIdx + 2'd1;
                    if (byteIdx == 2'd3) begin
                        imWeNext      = 1'b1;
                        imWDataNext   = {wordAsm, rxShift};
                        wordsLeftNext = wordsLeft - 16'd1;
                        if (wordsLeft == 16'd1)
                            stateNext = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rxShift == csum)
                        cpuRstNext = 1'b0;
                    else
                        loadErrNext = 1'b1;
                    stateNext = ST_IDLE;
                end
                default: stateNext = ST_IDLE;
            endcase
        end
`ifdef SM_UART_LOADER_TIMEOUT_EN
        else if (timeoutHit) begin
            loadErrNext = 1'b1;
            stateNext   = ST_IDLE;
        end
`endif
    end

endmodule
